// File: rtl/pcie_mst_arb_if.sv
// Requester and master-FIFO write-path signals shared between the two TLP
// sources and the pcie_mst_arb arbiter.
interface pcie_mst_arb_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [17:0] req0_data;
  logic        req1_valid;
  logic        req1_ready;
  logic [17:0] req1_data;
  logic        mst_wr_en;
  logic [17:0] mst_din;
  logic        mst_full;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, mst_full,
    output req0_ready, req1_ready, mst_wr_en, mst_din
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, mst_full,
    input  req0_ready, req1_ready, mst_wr_en, mst_din
  );
endinterface

// File: rtl/pcie_mst_arb.sv
// Packet-atomic two-way round-robin arbiter for the pcie_tlp master write path,
// with per-requester packet counters and sticky protocol-error flags.
module pcie_mst_arb #(
  parameter int unsigned STALL_TIMEOUT = 255,
  parameter int unsigned CNT_W         = 16
) (
  input  logic               pcie_clk,
  input  logic               sys_rst_n,
  pcie_mst_arb_if.slave      bus,
  input  logic               err_clr,
  output logic [1:0]         gnt,
  output logic [CNT_W-1:0]   pkt_cnt0,
  output logic [CNT_W-1:0]   pkt_cnt1,
  output logic               err_sop,
  output logic               err_stall
);

  localparam int unsigned SOP_B     = 17;
  localparam int unsigned EOP_B     = 16;
  localparam logic [7:0]  STALL_LIM = 8'(STALL_TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               rr_last_q, rr_last_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [7:0]         stall_q, stall_d;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d;
  logic [CNT_W-1:0]   cnt1_q, cnt1_d;
  logic               err_sop_q, err_sop_d;
  logic               err_stall_q, err_stall_d;

  logic               cand0, cand1, drop0, drop1;
  logic               own_valid, wr_en, ready0, ready1;
  logic               set_sop, set_stall;
  logic [17:0]        own_data, din;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    gnt_d     = gnt_q;
    stall_d   = stall_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    set_sop   = 1'b0;
    set_stall = 1'b0;
    wr_en     = 1'b0;
    ready0    = 1'b0;
    ready1    = 1'b0;
    din       = '0;
    cand0     = bus.req0_valid & bus.req0_data[SOP_B];
    cand1     = bus.req1_valid & bus.req1_data[SOP_B];
    drop0     = bus.req0_valid & ~bus.req0_data[SOP_B];
    drop1     = bus.req1_valid & ~bus.req1_data[SOP_B];
    own_valid = owner_q ? bus.req1_valid : bus.req0_valid;
    own_data  = owner_q ? bus.req1_data  : bus.req0_data;

    case (state_q)
      IDLE: begin
        // Stray mid-packet words are swallowed so a confused requester cannot wedge the bus.
        ready0  = drop0;
        ready1  = drop1;
        set_sop = drop0 | drop1;
        stall_d = '0;
        if (cand0 | cand1) begin
          owner_d   = (cand0 & cand1) ? ~rr_last_q : cand1;
          rr_last_d = owner_d;
          gnt_d     = owner_d ? 2'b10 : 2'b01;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        din    = own_data;
        wr_en  = own_valid & ~bus.mst_full;
        ready0 = wr_en & ~owner_q;
        ready1 = wr_en & owner_q;
        if (wr_en) begin
          stall_d = '0;
          if (own_data[EOP_B]) begin
            state_d = IDLE;
            gnt_d   = 2'b00;
            if (owner_q) cnt1_d = cnt1_q + 1'b1;
            else         cnt0_d = cnt0_q + 1'b1;
          end
        end else if (!own_valid && stall_q != STALL_LIM) begin
          // Counter saturates at the limit; the flag fires once on arrival.
          stall_d   = stall_q + 8'd1;
          set_stall = (stall_q == STALL_LIM - 8'd1);
        end
      end
      default: state_d = IDLE;
    endcase

    err_sop_d   = (err_sop_q & ~err_clr) | set_sop;
    err_stall_d = (err_stall_q & ~err_clr) | set_stall;
  end

  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      rr_last_q   <= 1'b1;
      gnt_q       <= 2'b00;
      stall_q     <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
      err_sop_q   <= 1'b0;
      err_stall_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      gnt_q       <= gnt_d;
      stall_q     <= stall_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
      err_sop_q   <= err_sop_d;
      err_stall_q <= err_stall_d;
    end
  end

  assign bus.mst_wr_en  = wr_en;
  assign bus.mst_din    = din;
  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign gnt            = gnt_q;
  assign pkt_cnt0       = cnt0_q;
  assign pkt_cnt1       = cnt1_q;
  assign err_sop        = err_sop_q;
  assign err_stall      = err_stall_q;

endmodule

// File: tb/tb_pcie_mst_arb.sv
// Directed bench for pcie_mst_arb: contention, backpressure, single-word
// packets, missing SOP, stall timeout and reset mid-packet.
module tb_pcie_mst_arb;
  localparam int CNT_W = 16;

  logic             pcie_clk  = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             err_clr   = 1'b0;
  logic [1:0]       gnt;
  logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;
  logic             err_sop, err_stall;

  pcie_mst_arb_if bus();

  pcie_mst_arb #(.STALL_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .pcie_clk  (pcie_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus),
    .err_clr   (err_clr),
    .gnt       (gnt),
    .pkt_cnt0  (pkt_cnt0),
    .pkt_cnt1  (pkt_cnt1),
    .err_sop   (err_sop),
    .err_stall (err_stall)
  );

  always #5 pcie_clk = ~pcie_clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic        en0 = 1'b1;
  logic        en1 = 1'b1;
  logic        r0  = 1'b0;
  logic        r1  = 1'b0;

  function automatic logic [17:0] mkw(input logic sop, input logic eop, input logic [15:0] d);
    return {sop, eop, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_pkt(input int who, input logic [15:0] base, input int n);
    for (int w = 0; w < n; w++) begin
      if (who == 0) q0.push_back(mkw(w == 0, w == n - 1, base + 16'(w)));
      else          q1.push_back(mkw(w == 0, w == n - 1, base + 16'(w)));
    end
  endtask

  // Called just after a falling edge: present queue heads, settle, record ready.
  task automatic drive();
    bus.req0_valid = en0 && (q0.size() != 0);
    bus.req0_data  = (q0.size() != 0) ? q0[0] : 18'h0;
    bus.req1_valid = en1 && (q1.size() != 0);
    bus.req1_data  = (q1.size() != 0) ? q1[0] : 18'h0;
    #1;
    r0 = bus.req0_ready;
    r1 = bus.req1_ready;
  endtask

  task automatic tick();
    @(negedge pcie_clk);
    if (r0 && q0.size() != 0) void'(q0.pop_front());
    if (r1 && q1.size() != 0) void'(q1.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    bus.mst_full   = 1'b0;

    // Reset state
    @(negedge pcie_clk);
    #1;
    chk("rst_gnt",    32'(gnt), 32'h0);
    chk("rst_we",     32'(bus.mst_wr_en), 32'h0);
    chk("rst_din",    32'(bus.mst_din), 32'h0);
    chk("rst_cnt0",   32'(pkt_cnt0), 32'h0);
    chk("rst_cnt1",   32'(pkt_cnt1), 32'h0);
    chk("rst_esop",   32'(err_sop), 32'h0);
    chk("rst_estall", 32'(err_stall), 32'h0);
    @(negedge pcie_clk);
    sys_rst_n = 1'b1;

    // Contention: two 4-word packets per requester, alternating ownership
    push_pkt(0, 16'hA000, 4);
    push_pkt(0, 16'hA010, 4);
    push_pkt(1, 16'hB000, 4);
    push_pkt(1, 16'hB010, 4);
    for (int c = 0; c < 20; c++) begin
      int slot, pos, own;
      logic [17:0] ed;
      slot = c / 5;
      pos  = c % 5;
      own  = slot % 2;
      ed   = mkw(pos == 1, pos == 4, (own ? 16'hB000 : 16'hA000) + 16'((slot / 2) * 16) + 16'(pos - 1));
      drive();
      chk($sformatf("cont_we[%0d]", c),  32'(bus.mst_wr_en), (pos == 0) ? 32'h0 : 32'h1);
      chk($sformatf("cont_din[%0d]", c), 32'(bus.mst_din),   (pos == 0) ? 32'h0 : 32'(ed));
      chk($sformatf("cont_gnt[%0d]", c), 32'(gnt), (pos == 0) ? 32'h0 : (own ? 32'h2 : 32'h1));
      tick();
    end
    drive();
    chk("cont_cnt0", 32'(pkt_cnt0), 32'd2);
    chk("cont_cnt1", 32'(pkt_cnt1), 32'd2);
    chk("cont_idle", 32'(gnt), 32'h0);

    // Backpressure: full during BUSY cycles 2..4
    push_pkt(0, 16'hC000, 3);
    for (int t = 0; t < 7; t++) begin
      logic        ewe;
      logic [17:0] ed;
      bus.mst_full = (t >= 2 && t <= 4);
      ewe = (t == 1) || (t >= 5);
      if (t == 0)      ed = 18'h0;
      else if (t == 1) ed = mkw(1'b1, 1'b0, 16'hC000);
      else if (t == 6) ed = mkw(1'b0, 1'b1, 16'hC002);
      else             ed = mkw(1'b0, 1'b0, 16'hC001);
      drive();
      chk($sformatf("bp_we[%0d]", t),  32'(bus.mst_wr_en), 32'(ewe));
      chk($sformatf("bp_rdy[%0d]", t), 32'(bus.req0_ready), 32'(ewe));
      chk($sformatf("bp_din[%0d]", t), 32'(bus.mst_din), 32'(ed));
      tick();
    end
    bus.mst_full = 1'b0;
    drive();
    chk("bp_gnt",  32'(gnt), 32'h0);
    chk("bp_cnt0", 32'(pkt_cnt0), 32'd3);

    // Single-word packet from requester 1
    q1.push_back(18'h3ABCD);
    drive();
    chk("sw_we0", 32'(bus.mst_wr_en), 32'h0);
    tick();
    drive();
    chk("sw_we1",  32'(bus.mst_wr_en), 32'h1);
    chk("sw_din",  32'(bus.mst_din), 32'h3ABCD);
    chk("sw_gnt",  32'(gnt), 32'h2);
    chk("sw_rdy1", 32'(bus.req1_ready), 32'h1);
    tick();
    drive();
    chk("sw_idle", 32'(gnt), 32'h0);
    chk("sw_cnt1", 32'(pkt_cnt1), 32'd3);

    // Missing SOP while idle
    q0.push_back(18'h01234);
    drive();
    chk("nosop_rdy", 32'(bus.req0_ready), 32'h1);
    chk("nosop_we",  32'(bus.mst_wr_en), 32'h0);
    tick();
    err_clr = 1'b1;
    drive();
    chk("nosop_err", 32'(err_sop), 32'h1);
    chk("nosop_gnt", 32'(gnt), 32'h0);
    tick();
    err_clr = 1'b0;
    drive();
    chk("nosop_clr", 32'(err_sop), 32'h0);

    // Stall timeout of 4 with six idle cycles mid-packet
    push_pkt(0, 16'hD000, 3);
    drive();
    tick();
    drive();
    chk("st_we_sop", 32'(bus.mst_wr_en), 32'h1);
    chk("st_din0",   32'(bus.mst_din), 32'(mkw(1'b1, 1'b0, 16'hD000)));
    tick();
    en0 = 1'b0;
    for (int t = 2; t < 8; t++) begin
      drive();
      chk($sformatf("st_we[%0d]", t),  32'(bus.mst_wr_en), 32'h0);
      chk($sformatf("st_gnt[%0d]", t), 32'(gnt), 32'h1);
      chk($sformatf("st_err[%0d]", t), 32'(err_stall), (t >= 6) ? 32'h1 : 32'h0);
      tick();
    end
    en0 = 1'b1;
    drive();
    chk("st_we1",  32'(bus.mst_wr_en), 32'h1);
    chk("st_din1", 32'(bus.mst_din), 32'(mkw(1'b0, 1'b0, 16'hD001)));
    tick();
    drive();
    chk("st_din2", 32'(bus.mst_din), 32'(mkw(1'b0, 1'b1, 16'hD002)));
    tick();
    drive();
    chk("st_gnt_end", 32'(gnt), 32'h0);
    chk("st_cnt0",    32'(pkt_cnt0), 32'd4);
    chk("st_sticky",  32'(err_stall), 32'h1);

    // Reset asserted mid-packet
    push_pkt(0, 16'hE000, 4);
    drive();
    tick();
    drive();
    tick();
    drive();
    chk("rm_we_pre", 32'(bus.mst_wr_en), 32'h1);
    tick();
    drive();
    sys_rst_n = 1'b0;
    #1;
    chk("rm_gnt",    32'(gnt), 32'h0);
    chk("rm_we",     32'(bus.mst_wr_en), 32'h0);
    chk("rm_cnt0",   32'(pkt_cnt0), 32'h0);
    chk("rm_cnt1",   32'(pkt_cnt1), 32'h0);
    chk("rm_estall", 32'(err_stall), 32'h0);
    chk("rm_esop",   32'(err_sop), 32'h0);
    q0.delete();
    q1.delete();
    r0 = 1'b0;
    r1 = 1'b0;
    @(negedge pcie_clk);
    sys_rst_n = 1'b1;
    push_pkt(0, 16'hF000, 1);
    push_pkt(1, 16'hF100, 1);
    drive();
    chk("rr_gnt0", 32'(gnt), 32'h0);
    tick();
    drive();
    chk("rr_gnt1", 32'(gnt), 32'h1);
    chk("rr_din1", 32'(bus.mst_din), 32'(mkw(1'b1, 1'b1, 16'hF000)));
    tick();
    drive();
    chk("rr_gnt2", 32'(gnt), 32'h0);
    tick();
    drive();
    chk("rr_gnt3", 32'(gnt), 32'h2);
    chk("rr_din3", 32'(bus.mst_din), 32'(mkw(1'b1, 1'b1, 16'hF100)));
    tick();
    drive();
    chk("rr_cnt0", 32'(pkt_cnt0), 32'd1);
    chk("rr_cnt1", 32'(pkt_cnt1), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
